// File: rtl/mask_pixel_expander.sv
// Expands packed 1-bit match masks (32 pixels per word, bit 0 first) into an
// RGB565 pixel stream, tracking column/line position and frame boundaries.
`timescale 1ns/1ps
module mask_pixel_expander #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        enable,
    input  logic [15:0] fgColor,
    input  logic [15:0] bgColor,
    input  logic [31:0] maskWord,
    input  logic        maskValid,
    output logic        maskReady,
    output logic [15:0] pixelData,
    output logic        pixelValid,
    input  logic        pixelReady,
    output logic        pixelFirst,
    output logic        pixelLineEnd,
    output logic        frameDone
);

    localparam int COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int LINE_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state;
    logic [31:0]         word_q;
    logic [4:0]          index_q;
    logic [COL_W-1:0]    col_q;
    logic [LINE_W-1:0]   line_q;
    logic [15:0]         fg_q;
    logic [15:0]         bg_q;

    logic in_shift;
    logic line_end;
    logic frame_last;
    logic word_end;
    logic pixel_xfer;
    logic mask_xfer;

    assign in_shift   = (state == S_SHIFT);
    assign line_end   = (col_q == COL_LAST);
    assign frame_last = line_end & (line_q == LINE_LAST);
    assign word_end   = (index_q == 5'd31);

    // The next word is only taken in SHIFT when the current pixel leaves this
    // very cycle, so a refill never stalls the stream.
    assign maskReady    = (state == S_LOAD) |
                          (in_shift & word_end & pixelReady & ~frame_last);
    assign pixelValid   = in_shift;
    assign pixelData    = in_shift ? (word_q[index_q] ? fg_q : bg_q) : 16'h0000;
    assign pixelFirst   = in_shift & (col_q == '0) & (line_q == '0);
    assign pixelLineEnd = in_shift & line_end;
    assign frameDone    = (state == S_DONE);

    assign pixel_xfer = pixelValid & pixelReady;
    assign mask_xfer  = maskValid & maskReady;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state   <= S_IDLE;
            word_q  <= '0;
            index_q <= '0;
            col_q   <= '0;
            line_q  <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        fg_q  <= fgColor;
                        bg_q  <= bgColor;
                        state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (mask_xfer) begin
                        word_q  <= maskWord;
                        index_q <= '0;
                        state   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (pixel_xfer) begin
                        if (line_end) begin
                            col_q  <= '0;
                            line_q <= frame_last ? '0 : line_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end

                        // Leftover bits of the final word are dropped so the
                        // next frame always starts on a fresh word.
                        if (frame_last) begin
                            index_q <= '0;
                            state   <= S_DONE;
                        end else if (word_end) begin
                            index_q <= '0;
                            if (mask_xfer) begin
                                word_q <= maskWord;
                            end else begin
                                state <= S_LOAD;
                            end
                        end else begin
                            index_q <= index_q + 5'd1;
                        end
                    end
                end

                S_DONE: begin
                    col_q   <= '0;
                    line_q  <= '0;
                    index_q <= '0;
                    if (enable) begin
                        fg_q  <= fgColor;
                        bg_q  <= bgColor;
                        state <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mask_pixel_expander.sv
// Scoreboard bench: an 8x4 instance (single-word frames) and a 40x2 instance
// (streaming, backpressure, colour latch, mid-frame reset).
`timescale 1ns/1ps
module tb_mask_pixel_expander;

    typedef struct packed {
        logic [15:0] d;
        logic        first;
        logic        lend;
        logic        b31;
        logic        flast;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        nReset, enable;
    logic [15:0] fgColor, bgColor;

    logic [31:0] maskWord_a, maskWord_b;
    logic        maskValid_a, maskValid_b, maskReady_a, maskReady_b;
    logic [15:0] pixelData_a, pixelData_b;
    logic        pixelValid_a, pixelValid_b, pixelReady_a, pixelReady_b;
    logic        pixelFirst_a, pixelFirst_b, pixelLineEnd_a, pixelLineEnd_b;
    logic        frameDone_a, frameDone_b;

    mask_pixel_expander #(.WIDTH(8), .HEIGHT(4)) dut_a (
        .clock(clock), .nReset(nReset), .enable(enable),
        .fgColor(fgColor), .bgColor(bgColor),
        .maskWord(maskWord_a), .maskValid(maskValid_a), .maskReady(maskReady_a),
        .pixelData(pixelData_a), .pixelValid(pixelValid_a), .pixelReady(pixelReady_a),
        .pixelFirst(pixelFirst_a), .pixelLineEnd(pixelLineEnd_a), .frameDone(frameDone_a)
    );

    mask_pixel_expander #(.WIDTH(40), .HEIGHT(2)) dut_b (
        .clock(clock), .nReset(nReset), .enable(enable),
        .fgColor(fgColor), .bgColor(bgColor),
        .maskWord(maskWord_b), .maskValid(maskValid_b), .maskReady(maskReady_b),
        .pixelData(pixelData_b), .pixelValid(pixelValid_b), .pixelReady(pixelReady_b),
        .pixelFirst(pixelFirst_b), .pixelLineEnd(pixelLineEnd_b), .frameDone(frameDone_b)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    exp_t        qa[$], qb[$];
    logic [31:0] mqa[$], mqb[$];
    int          acc[2];
    int          popped[2];
    int          first_cyc[2];
    int          last_cyc[2];
    logic        stall_prev[2];
    logic [17:0] held[2];
    logic [31:0] wbuf[0:2];
    bit          rnd_in  = 1'b0;
    bit          rnd_rdy = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_words(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        wbuf[0] = w0;
        wbuf[1] = w1;
        wbuf[2] = w2;
    endtask

    // Expected pixels of one whole frame plus the words that feed it.
    task automatic push_frame(input int w, input int W, input int H,
                              input logic [15:0] fg, input logic [15:0] bg);
        exp_t        e;
        logic [31:0] wv;
        int          nw;
        nw = (W * H + 31) / 32;
        for (int p = 0; p < W * H; p++) begin
            wv      = wbuf[p / 32];
            e.d     = wv[p % 32] ? fg : bg;
            e.first = (p == 0);
            e.lend  = ((p % W) == W - 1);
            e.b31   = ((p % 32) == 31);
            e.flast = (p == W * H - 1);
            if (w == 0) qa.push_back(e); else qb.push_back(e);
        end
        for (int i = 0; i < nw; i++) begin
            if (w == 0) mqa.push_back(wbuf[i]); else mqb.push_back(wbuf[i]);
        end
    endtask

    task automatic check_outs(input string tag, input int w);
        logic mr, pv, pf, pl, fd;
        logic [15:0] pd;
        mr = (w == 0) ? maskReady_a    : maskReady_b;
        pv = (w == 0) ? pixelValid_a   : pixelValid_b;
        pf = (w == 0) ? pixelFirst_a   : pixelFirst_b;
        pl = (w == 0) ? pixelLineEnd_a : pixelLineEnd_b;
        fd = (w == 0) ? frameDone_a    : frameDone_b;
        pd = (w == 0) ? pixelData_a    : pixelData_b;
        chk($sformatf("%s_maskReady_%0d", tag, w),    32'(mr), 32'd0);
        chk($sformatf("%s_pixelValid_%0d", tag, w),   32'(pv), 32'd0);
        chk($sformatf("%s_pixelFirst_%0d", tag, w),   32'(pf), 32'd0);
        chk($sformatf("%s_pixelLineEnd_%0d", tag, w), 32'(pl), 32'd0);
        chk($sformatf("%s_frameDone_%0d", tag, w),    32'(fd), 32'd0);
        chk($sformatf("%s_pixelData_%0d", tag, w),    32'(pd), 32'd0);
    endtask

    task automatic wait_fd(input int w, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clock);
            if ((w == 0) ? frameDone_a : frameDone_b) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_done_timeout_%0d: got no pulse expected pulse within %0d cycles", w, lim);
        end
    endtask

    task automatic wait_pop(input int target, input int lim);
        int i;
        i = 0;
        while (popped[1] < target && i < lim) begin
            @(negedge clock);
            i++;
        end
        if (popped[1] < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL pixel_count_timeout: got %0d expected %0d", popped[1], target);
        end
    endtask

    task automatic mon(input int w, input logic pv, input logic pr, input logic mr,
                       input logic [15:0] pd, input logic pf, input logic pl);
        exp_t e;
        logic have;
        have = (w == 0) ? (qa.size() > 0) : (qb.size() > 0);
        if (pv && stall_prev[w])
            chk($sformatf("hold_stable_%0d", w), 32'({pd, pf, pl}), 32'(held[w]));
        if (pv && !have) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pixel_%0d: got %h expected no pixel", w, pd);
        end else if (pv) begin
            e = (w == 0) ? qa[0] : qb[0];
            chk($sformatf("maskReady_in_shift_%0d", w), 32'(mr), 32'(e.b31 & pr & ~e.flast));
            if (pr) begin
                if (w == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                chk($sformatf("pixelData_%0d_n%0d", w, popped[w]), 32'(pd), 32'(e.d));
                chk($sformatf("pixelFirst_%0d_n%0d", w, popped[w]), 32'(pf), 32'(e.first));
                chk($sformatf("pixelLineEnd_%0d_n%0d", w, popped[w]), 32'(pl), 32'(e.lend));
                popped[w]++;
                if (e.first) first_cyc[w] = cyc;
                if (e.flast) last_cyc[w] = cyc;
            end
        end
        stall_prev[w] = pv & ~pr;
        held[w]       = {pd, pf, pl};
    endtask

    // Monitor: compares every pixel transfer against the scoreboard queues.
    initial begin
        for (int i = 0; i < 2; i++) begin
            popped[i] = 0; first_cyc[i] = 0; last_cyc[i] = 0;
            stall_prev[i] = 1'b0; held[i] = '0;
        end
        forever begin
            @(negedge clock);
            if (nReset) begin
                mon(0, pixelValid_a, pixelReady_a, maskReady_a, pixelData_a, pixelFirst_a, pixelLineEnd_a);
                mon(1, pixelValid_b, pixelReady_b, maskReady_b, pixelData_b, pixelFirst_b, pixelLineEnd_b);
            end
        end
    end

    initial begin
        logic xa;
        acc[0] = 0;
        maskValid_a = 1'b0;
        maskWord_a  = '0;
        forever begin
            @(negedge clock);
            xa = maskValid_a & maskReady_a;
            if (xa) acc[0]++;
            step();
            if (xa && mqa.size() > 0) void'(mqa.pop_front());
            if (mqa.size() > 0) begin
                maskValid_a = 1'b1;
                maskWord_a  = mqa[0];
            end else begin
                maskValid_a = rnd_in ? 1'($urandom_range(0, 1)) : 1'b0;
                maskWord_a  = $urandom;
            end
        end
    end

    initial begin
        logic xb;
        acc[1] = 0;
        maskValid_b = 1'b0;
        maskWord_b  = '0;
        forever begin
            @(negedge clock);
            xb = maskValid_b & maskReady_b;
            if (xb) acc[1]++;
            step();
            if (xb && mqb.size() > 0) void'(mqb.pop_front());
            if (mqb.size() > 0) begin
                maskValid_b = 1'b1;
                maskWord_b  = mqb[0];
            end else begin
                maskValid_b = rnd_in ? 1'($urandom_range(0, 1)) : 1'b0;
                maskWord_b  = $urandom;
            end
        end
    end

    initial begin
        forever begin
            step();
            if (rnd_rdy) pixelReady_b = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int a0, base;
        nReset = 1'b1; enable = 1'b0; fgColor = '0; bgColor = '0;
        pixelReady_a = 1'b0; pixelReady_b = 1'b0; rnd_in = 1'b1;
        #2 nReset = 1'b0;

        // Reset with random inputs, then release with enable low.
        for (int i = 0; i < 4; i++) begin
            step();
            enable       = 1'($urandom_range(0, 1));
            fgColor      = 16'($urandom);
            bgColor      = 16'($urandom);
            pixelReady_a = 1'($urandom_range(0, 1));
            pixelReady_b = 1'($urandom_range(0, 1));
        end
        @(negedge clock);
        check_outs("in_reset", 0);
        check_outs("in_reset", 1);
        step();
        enable = 1'b0; rnd_in = 1'b0; nReset = 1'b1;
        pixelReady_a = 1'b0; pixelReady_b = 1'b0;
        repeat (3) step();
        @(negedge clock);
        check_outs("released", 0);
        check_outs("released", 1);

        // Single-word frame on the 8x4 instance.
        step();
        fgColor = 16'hF800; bgColor = 16'h001F; pixelReady_a = 1'b1;
        set_words(32'hA5A5A5A5, 32'h0, 32'h0);
        push_frame(0, 8, 4, 16'hF800, 16'h001F);
        enable = 1'b1;
        wait_fd(0, 200, ok);
        if (ok) begin
            chk("frameDone_after_last_pixel_a", 32'(cyc), 32'(last_cyc[0] + 1));
            @(negedge clock);
            chk("frameDone_single_cycle_a", 32'(frameDone_a), 32'd0);
            chk("maskReady_after_done_a", 32'(maskReady_a), 32'd1);
        end

        // Streaming, two frames back to back on the 40x2 instance.
        step();
        pixelReady_b = 1'b1;
        a0 = acc[1];
        set_words(32'hF0F03C3C, 32'h0FF0AA55, 32'hDEAD1234);
        push_frame(1, 40, 2, 16'hF800, 16'h001F);
        set_words(32'h80017FFE, 32'h5555CCCC, 32'h0000FFFF);
        push_frame(1, 40, 2, 16'hF800, 16'h001F);
        wait_fd(1, 400, ok);
        chk("stream_span_f1", 32'(last_cyc[1] - first_cyc[1]), 32'd79);
        chk("stream_words_f1", 32'(acc[1] - a0), 32'd3);
        step();
        enable = 1'b0;
        wait_fd(1, 400, ok);
        chk("stream_span_f2", 32'(last_cyc[1] - first_cyc[1]), 32'd79);
        chk("stream_words_f2", 32'(acc[1] - a0), 32'd6);
        @(negedge clock);
        chk("idle_after_disable_pixelValid", 32'(pixelValid_b), 32'd0);
        chk("idle_after_disable_maskReady", 32'(maskReady_b), 32'd0);
        repeat (2) @(negedge clock);
        chk("idle_stays_maskReady", 32'(maskReady_b), 32'd0);

        // Random backpressure.
        step();
        set_words($urandom, $urandom, $urandom);
        push_frame(1, 40, 2, 16'hF800, 16'h001F);
        rnd_rdy = 1'b1;
        enable  = 1'b1;
        wait_fd(1, 2000, ok);
        step();
        rnd_rdy = 1'b0;
        pixelReady_b = 1'b1;

        // Foreground change mid-frame takes effect on the next frame only.
        set_words(32'hFFFFFFFF, 32'h12345678, 32'hFFFF00FF);
        push_frame(1, 40, 2, 16'hF800, 16'h001F);
        set_words(32'hFFFFFFFF, 32'h87654321, 32'h0000FF00);
        push_frame(1, 40, 2, 16'h07E0, 16'h001F);
        base = popped[1];
        wait_pop(base + 10, 400);
        step();
        fgColor = 16'h07E0;
        wait_fd(1, 400, ok);
        wait_fd(1, 400, ok);

        // Reset in the middle of a frame.
        step();
        set_words(32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA);
        push_frame(1, 40, 2, 16'h07E0, 16'h001F);
        base = popped[1];
        wait_pop(base + 20, 400);
        @(posedge clock);
        #2 nReset = 1'b0;
        #1;
        check_outs("mid_frame_reset", 1);
        qb.delete();
        mqb.delete();
        maskValid_b = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        set_words(32'h0000C001, 32'h33333333, 32'h0000F00F);
        push_frame(1, 40, 2, 16'h07E0, 16'h001F);
        nReset = 1'b1;
        wait_fd(1, 400, ok);

        step();
        enable = 1'b0;
        repeat (4) step();
        chk("scoreboard_a_drained", 32'(qa.size()), 32'd0);
        chk("scoreboard_b_drained", 32'(qb.size()), 32'd0);
        chk("words_b_consumed", 32'(mqb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
